// File: rtl/sram_io_host_if.sv
// Host request/response and serial SRAM-slave signals of sram_io_host.
// master = the host controller view, slave = the requester/SRAM-slave environment view.
interface sram_io_host_if #(
    parameter int unsigned MEMORY_DATA_WIDTH = 8,
    parameter int unsigned MEMORY_ADDR_WIDTH = 9
);
    logic                         START;
    logic                         WR;
    logic [MEMORY_ADDR_WIDTH-1:0] ADDR;
    logic [MEMORY_DATA_WIDTH-1:0] WDATA;
    logic                         BUSY;
    logic                         DONE;
    logic                         ERR;
    logic [MEMORY_DATA_WIDTH-1:0] RDATA;
    logic                         S_BGN;
    logic                         S_LOAD_N;
    logic [1:0]                   S_CTRL;
    logic                         S_SI;
    logic                         S_SO;
    logic                         S_RDY;

    modport master (
        input  START, WR, ADDR, WDATA, S_SO, S_RDY,
        output BUSY, DONE, ERR, RDATA, S_BGN, S_LOAD_N, S_CTRL, S_SI
    );

    modport slave (
        output START, WR, ADDR, WDATA, S_SO, S_RDY,
        input  BUSY, DONE, ERR, RDATA, S_BGN, S_LOAD_N, S_CTRL, S_SI
    );
endinterface

// File: rtl/sram_io_host.sv
// Host controller for a serially-loaded SRAM slave: LOAD (shift frame in),
// EXEC (read/write strobe), UNLOAD (shift read data out), with a WAIT timeout.
module sram_io_host #(
    parameter int unsigned MEMORY_DATA_WIDTH = 8,
    parameter int unsigned MEMORY_ADDR_WIDTH = 9,
    parameter int unsigned TIMEOUT           = 255
) (
    input  logic                 CLK,
    input  logic                 BGN,
    sram_io_host_if.master       bus
);
    localparam int unsigned DW      = MEMORY_DATA_WIDTH;
    localparam int unsigned AW      = MEMORY_ADDR_WIDTH;
    localparam int unsigned N       = AW + DW + 1;
    localparam int unsigned CNT_MAX = (N > TIMEOUT) ? N : TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned FIDX_W  = $clog2(N);
    localparam int unsigned DIDX_W  = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [2:0] {
        ST_IDLE, ST_PRE, ST_LDN, ST_GAP, ST_SHIFT, ST_WAIT, ST_FIN
    } state_e;

    typedef enum logic [1:0] {
        PH_LOAD, PH_EXEC, PH_UNLOAD
    } phase_e;

    state_e           state_q, state_d;
    phase_e           phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wr_q, wr_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic             s_bgn_q, s_bgn_d;
    logic             s_load_n_q, s_load_n_d;
    logic [1:0]       s_ctrl_q, s_ctrl_d;
    logic             s_si_q, s_si_d;
    logic [N-1:0]     frame_c;

    // Serial frame, sent LSB first: dummy 0, then WDATA, then ADDR.
    assign frame_c = {addr_q, wdata_q, 1'b0};

    always_ff @(posedge CLK) begin
        if (!BGN) begin
            state_q    <= ST_IDLE;
            phase_q    <= PH_LOAD;
            cnt_q      <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            s_bgn_q    <= 1'b0;
            s_load_n_q <= 1'b1;
            s_ctrl_q   <= 2'b00;
            s_si_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            s_bgn_q    <= s_bgn_d;
            s_load_n_q <= s_load_n_d;
            s_ctrl_q   <= s_ctrl_d;
            s_si_q     <= s_si_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        s_bgn_d    = 1'b0;
        s_load_n_d = 1'b1;
        s_ctrl_d   = 2'b00;
        s_si_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.START) begin
                    wr_d    = bus.WR;
                    addr_d  = bus.ADDR;
                    wdata_d = bus.WDATA;
                    err_d   = 1'b0;
                    phase_d = PH_LOAD;
                    cnt_d   = '0;
                    state_d = ST_PRE;
                end
            end
            ST_PRE: state_d = ST_LDN;
            ST_LDN: begin
                cnt_d   = '0;
                state_d = (phase_q == PH_EXEC) ? ST_WAIT : ST_GAP;
            end
            ST_GAP: begin
                cnt_d   = '0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                // Read data returns LSB first over the first DW shift cycles.
                if (phase_q == PH_UNLOAD && cnt_q < CNT_W'(DW)) begin
                    rdata_d[DIDX_W'(cnt_q)] = bus.S_SO;
                end
                if (cnt_q == CNT_W'(N - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT: begin
                // S_RDY is checked before the timeout so a coincident ready wins.
                if (bus.S_RDY) begin
                    cnt_d = '0;
                    case (phase_q)
                        PH_LOAD: begin
                            phase_d = PH_EXEC;
                            state_d = ST_PRE;
                        end
                        PH_EXEC: begin
                            if (wr_q) begin
                                state_d = ST_FIN;
                            end else begin
                                phase_d = PH_UNLOAD;
                                state_d = ST_PRE;
                            end
                        end
                        default: state_d = ST_FIN;
                    endcase
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    state_d = ST_FIN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they line up with it once registered.
        busy_d     = state_d inside {ST_PRE, ST_LDN, ST_GAP, ST_SHIFT, ST_WAIT};
        done_d     = (state_d == ST_FIN);
        s_bgn_d    = state_d inside {ST_LDN, ST_GAP, ST_SHIFT, ST_WAIT};
        s_load_n_d = (state_d != ST_LDN);
        if (s_bgn_d && phase_d == PH_EXEC) begin
            s_ctrl_d = wr_d ? 2'b11 : 2'b01;
        end
        if (state_d == ST_SHIFT && phase_d == PH_LOAD) begin
            s_si_d = frame_c[FIDX_W'(cnt_d)];
        end
    end

    assign bus.BUSY     = busy_q;
    assign bus.DONE     = done_q;
    assign bus.ERR      = err_q;
    assign bus.RDATA    = rdata_q;
    assign bus.S_BGN    = s_bgn_q;
    assign bus.S_LOAD_N = s_load_n_q;
    assign bus.S_CTRL   = s_ctrl_q;
    assign bus.S_SI     = s_si_q;
endmodule

// File: tb/tb_sram_io_host.sv
// Directed bench for sram_io_host with a behavioural serial SRAM slave.
module tb_sram_io_host;
    localparam int unsigned DW  = 8;
    localparam int unsigned AW  = 9;
    localparam int unsigned TMO = 255;

    logic CLK = 1'b0;
    logic BGN = 1'b0;
    int   n_vec  = 0;
    int   n_miss = 0;
    int   cyc_no = 0;

    sram_io_host_if #(.MEMORY_DATA_WIDTH(DW), .MEMORY_ADDR_WIDTH(AW)) bus ();

    sram_io_host #(
        .MEMORY_DATA_WIDTH(DW),
        .MEMORY_ADDR_WIDTH(AW),
        .TIMEOUT(TMO)
    ) dut (
        .CLK(CLK),
        .BGN(BGN),
        .bus(bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc_no <= cyc_no + 1;

    // Slave model state and observation logs
    logic [7:0]  mem [0:511];
    logic [1:0]  cmd;
    logic [17:0] sh;
    logic [8:0]  s_addr;
    logic [7:0]  s_data;
    logic [7:0]  s_out;
    logic [5:0]  ctrl_log;
    logic [17:0] frame_log [4];
    int          cyc_l;
    int          slv_k;
    int          rdy_delay;
    int          ldn_n;
    int          frame_n;
    int          done_n;
    int          wait_start;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        ldn_n    = 0;
        ctrl_log = '0;
        frame_n  = 0;
        done_n   = 0;
        for (int i = 0; i < 4; i++) frame_log[i] = '0;
    endtask

    // Slave reacts to the outputs of the current cycle, just after the edge.
    initial begin
        bus.S_RDY = 1'b0;
        bus.S_SO  = 1'b0;
        cyc_l = 0; cmd = 2'b00; sh = '0; s_addr = '0; s_data = '0; s_out = '0;
        wait_start = 0;
        forever begin
            @(posedge CLK);
            #1;
            bus.S_RDY = 1'b0;
            bus.S_SO  = 1'b0;
            if (bus.DONE === 1'b1) done_n++;
            if (bus.S_BGN !== 1'b1) begin
                cyc_l = 0;
            end else if (bus.S_LOAD_N === 1'b0) begin
                cyc_l    = 0;
                cmd      = bus.S_CTRL;
                ldn_n++;
                ctrl_log = {ctrl_log[3:0], bus.S_CTRL};
                if (cmd == 2'b11) mem[s_addr] = s_data;
                if (cmd == 2'b01) s_out = mem[s_addr];
                if (cmd == 2'b00) sh = '0;
            end else begin
                cyc_l++;
                if (cmd == 2'b00) begin
                    if (cyc_l >= 2 && cyc_l <= 19) begin
                        slv_k     = cyc_l - 2;
                        sh[slv_k] = bus.S_SI;
                        if (slv_k < 8) bus.S_SO = s_out[slv_k];
                        if (cyc_l == 19) begin
                            if (frame_n < 4) frame_log[frame_n] = sh;
                            frame_n++;
                            s_addr = sh[17:9];
                            s_data = sh[8:1];
                        end
                    end
                    if (cyc_l == 20) wait_start = cyc_no;
                    if (cyc_l >= 20 && (cyc_l - 20) == rdy_delay) bus.S_RDY = 1'b1;
                end else begin
                    if (cyc_l == 1) wait_start = cyc_no;
                    if ((cyc_l - 1) == rdy_delay) bus.S_RDY = 1'b1;
                end
            end
        end
    end

    task automatic wait_done(input bit drop_start, output int ncyc, output int done_at);
        bit seen;
        seen    = 1'b0;
        ncyc    = 0;
        done_at = 0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge CLK);
            if (drop_start) bus.START = 1'b0;
            ncyc++;
            if (bus.DONE === 1'b1) begin
                seen    = 1'b1;
                done_at = cyc_no;
            end
        end
        if (!seen) check("done_wait", 32'(0), 32'(1));
    endtask

    task automatic run_txn(input logic wr, input logic [8:0] a, input logic [7:0] d,
                           output int ncyc, output int done_at);
        int n;
        @(negedge CLK);
        bus.START = 1'b1;
        bus.WR    = wr;
        bus.ADDR  = a;
        bus.WDATA = d;
        wait_done(1'b1, n, done_at);
        ncyc = n + 1;
        @(negedge CLK);
    endtask

    int  nc, da;
    bit  hit;

    initial begin
        bus.START = 1'b0;
        bus.WR    = 1'b0;
        bus.ADDR  = '0;
        bus.WDATA = '0;
        rdy_delay = 0;
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        mem[9'h0F0] = 8'hA7;
        clear_logs();

        // Reset values
        repeat (3) @(negedge CLK);
        check("rst_ctl", 32'({bus.BUSY, bus.DONE, bus.ERR, bus.S_BGN, bus.S_LOAD_N, bus.S_CTRL, bus.S_SI}), 32'h08);
        check("rst_rdata", 32'(bus.RDATA), 32'h0);
        BGN = 1'b1;

        // Write 0x3C to 0x1A5
        clear_logs();
        run_txn(1'b1, 9'h1A5, 8'h3C, nc, da);
        check("wr_frame", 32'(frame_log[0]), 32'h34A78);
        check("wr_ldn", 32'(ldn_n), 32'(2));
        check("wr_ctrl", 32'(ctrl_log[3:0]), 32'h3);
        check("wr_done", 32'(done_n), 32'(1));
        check("wr_err", 32'(bus.ERR), 32'h0);
        check("wr_mem", 32'(mem[9'h1A5]), 32'h3C);
        check("wr_cycles", 32'(nc), 32'(27));
        check("wr_rdata", 32'(bus.RDATA), 32'h0);

        // Read 0x0F0 (holds 0xA7)
        clear_logs();
        run_txn(1'b0, 9'h0F0, 8'h55, nc, da);
        check("rd_ldn", 32'(ldn_n), 32'(3));
        check("rd_ctrl", 32'(ctrl_log), 32'h04);
        check("rd_load_frame", 32'(frame_log[0]), 32'h1E0AA);
        check("rd_unload_si", 32'(frame_log[1]), 32'h0);
        check("rd_frames", 32'(frame_n), 32'(2));
        check("rd_rdata", 32'(bus.RDATA), 32'hA7);
        check("rd_done", 32'(done_n), 32'(1));
        check("rd_cycles", 32'(nc), 32'(49));

        // START held through a write: no restart until IDLE, accepted right after FIN
        clear_logs();
        @(negedge CLK);
        bus.START = 1'b1; bus.WR = 1'b1; bus.ADDR = 9'h033; bus.WDATA = 8'h5A;
        wait_done(1'b0, nc, da);
        check("held_ldn_at_fin", 32'(ldn_n), 32'(2));
        check("held_busy_fin", 32'(bus.BUSY), 32'h0);
        @(negedge CLK);
        check("held_busy_idle", 32'(bus.BUSY), 32'h0);
        @(negedge CLK);
        check("held_accept", 32'(bus.BUSY), 32'h1);
        bus.START = 1'b0;
        wait_done(1'b1, nc, da);
        @(negedge CLK);
        check("held_done_n", 32'(done_n), 32'(2));
        check("held_mem", 32'(mem[9'h033]), 32'h5A);
        check("wr_keeps_rdata", 32'(bus.RDATA), 32'hA7);

        // Slave never ready: timeout, sticky ERR, cleared by the next START
        clear_logs();
        rdy_delay = 100000;
        run_txn(1'b1, 9'h100, 8'hEE, nc, da);
        check("to_err", 32'(bus.ERR), 32'h1);
        check("to_latency", 32'(da - wait_start), 32'(TMO));
        check("to_done", 32'(done_n), 32'(1));
        check("to_ldn", 32'(ldn_n), 32'(1));
        check("to_mem", 32'(mem[9'h100]), 32'h0);
        rdy_delay = 0;
        @(negedge CLK);
        bus.START = 1'b1; bus.WR = 1'b1; bus.ADDR = 9'h100; bus.WDATA = 8'h77;
        @(negedge CLK);
        bus.START = 1'b0;
        check("err_clear", 32'({bus.ERR, bus.BUSY}), 32'h1);
        wait_done(1'b1, nc, da);
        check("err_clear_mem", 32'(mem[9'h100]), 32'h77);

        // Reset during SHIFT k=7, then a clean write
        @(negedge CLK);
        clear_logs();
        bus.START = 1'b1; bus.WR = 1'b1; bus.ADDR = 9'h0AA; bus.WDATA = 8'h99;
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge CLK);
            bus.START = 1'b0;
            if (bus.S_BGN === 1'b1 && cmd == 2'b00 && cyc_l == 9) hit = 1'b1;
        end
        check("mid_reach_k7", 32'(hit), 32'h1);
        BGN = 1'b0;
        @(negedge CLK);
        check("mid_rst_ctl", 32'({bus.BUSY, bus.DONE, bus.ERR, bus.S_BGN, bus.S_LOAD_N, bus.S_CTRL, bus.S_SI}), 32'h08);
        check("mid_rst_rdata", 32'(bus.RDATA), 32'h0);
        BGN = 1'b1;
        repeat (30) @(negedge CLK);
        check("mid_no_done", 32'(done_n), 32'(0));
        check("mid_mem", 32'(mem[9'h0AA]), 32'h0);
        clear_logs();
        run_txn(1'b1, 9'h00F, 8'hC3, nc, da);
        check("post_rst_mem", 32'(mem[9'h00F]), 32'hC3);
        check("post_rst_cycles", 32'(nc), 32'(27));
        check("post_rst_done", 32'(done_n), 32'(1));

        // Ready on the very cycle the timeout count is reached: ready wins
        clear_logs();
        rdy_delay = TMO - 1;
        run_txn(1'b1, 9'h1FF, 8'h81, nc, da);
        check("edge_err", 32'(bus.ERR), 32'h0);
        check("edge_mem", 32'(mem[9'h1FF]), 32'h81);
        check("edge_cycles", 32'(nc), 32'(535));
        check("edge_ldn", 32'(ldn_n), 32'(2));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
